atom_video_conditioner: RTL and testbench

- Sits between the Atom core's raw video outputs (2-bit R/G/B, hsync, vsync) and the scandoubler/OSD video stage, in the clk_video domain.
- Measures line length and frame height from the incoming syncs and tracks lock.
- Regenerates clean, programmable hblank/vblank windows and blacks out pixels outside the active window or while unlocked.
- Gives the downstream stage stable blanking independent of the core's internal timing.

---
 rtl/atom_video_conditioner.sv | 235 +++++++++++++++++++++++
 tb/tb_atom_video_conditioner.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atom_video_conditioner.sv
// Conditions raw Atom video: measures sync timing, tracks lock, regenerates blanking windows.
// Optional sync polarity auto-detection is built when VIDEO_COND_SYNC_POL_EN is defined.
module atom_video_conditioner #(
    parameter int unsigned COLOR_DEPTH = 2,
    parameter int unsigned H_W         = 11,
    parameter int unsigned V_W         = 10,
    parameter int unsigned H_ACTIVE    = 512,
    parameter int unsigned V_ACTIVE    = 192
) (
    input  logic                   clk_video,
    input  logic                   reset,
    input  logic                   ce_pix,
    input  logic [COLOR_DEPTH-1:0] r_in,
    input  logic [COLOR_DEPTH-1:0] g_in,
    input  logic [COLOR_DEPTH-1:0] b_in,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic [H_W-1:0]         h_start,
    input  logic [V_W-1:0]         v_start,
    output logic [COLOR_DEPTH-1:0] r_out,
    output logic [COLOR_DEPTH-1:0] g_out,
    output logic [COLOR_DEPTH-1:0] b_out,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic                   hblank_out,
    output logic                   vblank_out,
    output logic                   locked,
    output logic [H_W-1:0]         line_len,
    output logic [V_W-1:0]         frame_lines
);

    localparam int unsigned HE_W = H_W + 1;
    localparam int unsigned VE_W = V_W + 1;

    typedef enum logic [1:0] {ST_UNLOCKED, ST_ACQUIRE, ST_LOCKED} state_t;

    state_t                 state_q, state_d;
    logic [H_W-1:0]         hcnt_q, hcnt_d, line_len_q, line_len_d;
    logic [V_W-1:0]         vcnt_q, vcnt_d, frame_lines_q, frame_lines_d;
    logic                   hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic                   h_mis_q, h_mis_d, line_err_q, line_err_d;
    logic [COLOR_DEPTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic                   hsync_q, hsync_d, vsync_q, vsync_d;
    logic                   hblank_q, hblank_d, vblank_q, vblank_d;

    logic                   hs_n, vs_n, pol_chg;
    logic                   hs_edge, vs_edge, line_mis, frame_mis, sat, h_act, v_act;
    logic [H_W-1:0]         hcnt_inc;
    logic [HE_W-1:0]        h_end;
    logic [VE_W-1:0]        v_end;

`ifdef VIDEO_COND_SYNC_POL_EN
    // Polarity detection: a sync that is high for more than half its period is inverted.
    logic           hs_pol_q, hs_pol_d, vs_pol_q, vs_pol_d;
    logic           hs_raw_q, hs_raw_d, vs_raw_q, vs_raw_d;
    logic [H_W-1:0] hs_hi_q, hs_hi_d, hs_per_q, hs_per_d;
    logic [V_W-1:0] vs_hi_q, vs_hi_d, vs_per_q, vs_per_d;

    assign hs_n    = hsync_in ^ hs_pol_q;
    assign vs_n    = vsync_in ^ vs_pol_q;
    assign pol_chg = ce_pix & ((hs_pol_d != hs_pol_q) | (vs_pol_d != vs_pol_q));

    always_comb begin
        hs_pol_d = hs_pol_q;
        vs_pol_d = vs_pol_q;
        hs_raw_d = hs_raw_q;
        vs_raw_d = vs_raw_q;
        hs_hi_d  = hs_hi_q;
        hs_per_d = hs_per_q;
        vs_hi_d  = vs_hi_q;
        vs_per_d = vs_per_q;
        if (ce_pix) begin
            hs_raw_d = hsync_in;
            vs_raw_d = vsync_in;
            if (hsync_in & ~hs_raw_q) begin
                hs_pol_d = hs_hi_q > (hs_per_q >> 1);
                hs_hi_d  = H_W'(1);
                hs_per_d = H_W'(1);
            end else begin
                if (!(&hs_per_q)) hs_per_d = hs_per_q + H_W'(1);
                if (hsync_in && !(&hs_hi_q)) hs_hi_d = hs_hi_q + H_W'(1);
            end
            if (vsync_in & ~vs_raw_q) begin
                vs_pol_d = vs_hi_q > (vs_per_q >> 1);
                vs_hi_d  = V_W'(hs_edge & vsync_in);
                vs_per_d = V_W'(hs_edge);
            end else if (hs_edge) begin
                if (!(&vs_per_q)) vs_per_d = vs_per_q + V_W'(1);
                if (vsync_in && !(&vs_hi_q)) vs_hi_d = vs_hi_q + V_W'(1);
            end
        end
    end

    always_ff @(posedge clk_video) begin
        if (reset) begin
            hs_pol_q <= 1'b0;
            vs_pol_q <= 1'b0;
            hs_raw_q <= 1'b0;
            vs_raw_q <= 1'b0;
            hs_hi_q  <= '0;
            hs_per_q <= '0;
            vs_hi_q  <= '0;
            vs_per_q <= '0;
        end else begin
            hs_pol_q <= hs_pol_d;
            vs_pol_q <= vs_pol_d;
            hs_raw_q <= hs_raw_d;
            vs_raw_q <= vs_raw_d;
            hs_hi_q  <= hs_hi_d;
            hs_per_q <= hs_per_d;
            vs_hi_q  <= vs_hi_d;
            vs_per_q <= vs_per_d;
        end
    end
`else
    assign hs_n    = hsync_in;
    assign vs_n    = vsync_in;
    assign pol_chg = 1'b0;
`endif

    assign hs_edge   = hs_n & ~hs_prev_q;
    assign vs_edge   = vs_n & ~vs_prev_q;
    assign hcnt_inc  = hcnt_q + H_W'(1);
    assign line_mis  = hs_edge & (hcnt_inc != line_len_q);
    assign sat       = ~hs_edge & (&hcnt_q);
    assign frame_mis = vs_edge & (vcnt_q != frame_lines_q);
    // Window ends carry one extra bit so a late start never wraps into the visible area.
    assign h_end     = {1'b0, h_start} + HE_W'(H_ACTIVE);
    assign v_end     = {1'b0, v_start} + VE_W'(V_ACTIVE);
    assign h_act     = (state_q == ST_LOCKED) & (hcnt_q >= h_start) & ({1'b0, hcnt_q} < h_end);
    assign v_act     = (vcnt_q >= v_start) & ({1'b0, vcnt_q} < v_end);

    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        h_mis_d       = h_mis_q;
        line_err_d    = line_err_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        hblank_d      = hblank_q;
        vblank_d      = vblank_q;
        if (ce_pix) begin
            hs_prev_d = hs_n;
            vs_prev_d = vs_n;
            if (hs_edge) begin
                hcnt_d     = '0;
                line_len_d = hcnt_inc;
            end else if (!(&hcnt_q)) begin
                hcnt_d = hcnt_inc;
            end
            // Frame restart wins over a coincident line restart.
            if (vs_edge) begin
                vcnt_d        = '0;
                frame_lines_d = vcnt_q;
            end else if (hs_edge && !(&vcnt_q)) begin
                vcnt_d = vcnt_q + V_W'(1);
            end
            h_mis_d    = vs_edge ? 1'b0 : (h_mis_q | line_mis);
            line_err_d = vs_edge ? 1'b0 : (line_err_q | sat);
            case (state_q)
                ST_UNLOCKED: if (vs_edge) state_d = ST_ACQUIRE;
                ST_ACQUIRE:  if (vs_edge && !frame_mis && !(h_mis_q | line_mis) && !(line_err_q | sat))
                                 state_d = ST_LOCKED;
                ST_LOCKED:   if (line_mis || frame_mis || sat) state_d = ST_UNLOCKED;
                default:     state_d = ST_UNLOCKED;
            endcase
            if (pol_chg) state_d = ST_UNLOCKED;
            r_d      = (h_act & v_act) ? r_in : '0;
            g_d      = (h_act & v_act) ? g_in : '0;
            b_d      = (h_act & v_act) ? b_in : '0;
            hsync_d  = hs_n;
            vsync_d  = vs_n;
            hblank_d = ~h_act;
            vblank_d = ~(v_act & (state_q == ST_LOCKED));
        end
    end

    always_ff @(posedge clk_video) begin
        if (reset) begin
            state_q       <= ST_UNLOCKED;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            h_mis_q       <= 1'b0;
            line_err_q    <= 1'b0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            h_mis_q       <= h_mis_d;
            line_err_q    <= line_err_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
        end
    end

    assign r_out       = r_q;
    assign g_out       = g_q;
    assign b_out       = b_q;
    assign hsync_out   = hsync_q;
    assign vsync_out   = vsync_q;
    assign hblank_out  = hblank_q;
    assign vblank_out  = vblank_q;
    assign locked      = (state_q == ST_LOCKED);
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;

endmodule

// File: tb/tb_atom_video_conditioner.sv
// Randomized bench for atom_video_conditioner against a cycle-level behavioural model.
module tb_atom_video_conditioner;

    localparam int unsigned CD = 2;
    localparam int unsigned HW = 11;
    localparam int unsigned VW = 10;
    localparam int unsigned HA = 40;
    localparam int unsigned VA = 6;
    localparam int LINE  = 100;
    localparam int SHORT = 98;
    localparam int NL    = 12;
    localparam int HSW   = 8;
    localparam int HMAX  = 2047;
    localparam int VMAX  = 1023;

    logic          clk_video = 1'b0;
    logic          reset, ce_pix, hsync_in, vsync_in;
    logic [CD-1:0] r_in, g_in, b_in, r_out, g_out, b_out;
    logic          hsync_out, vsync_out, hblank_out, vblank_out, locked;
    logic [HW-1:0] h_start, line_len;
    logic [VW-1:0] v_start, frame_lines;

    atom_video_conditioner #(.COLOR_DEPTH(CD), .H_W(HW), .V_W(VW), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
        .clk_video(clk_video), .reset(reset), .ce_pix(ce_pix),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .h_start(h_start), .v_start(v_start),
        .r_out(r_out), .g_out(g_out), .b_out(b_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblank_out(hblank_out), .vblank_out(vblank_out), .locked(locked),
        .line_len(line_len), .frame_lines(frame_lines)
    );

    always #5 clk_video = ~clk_video;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Raw timing generator state
    int px = 0, ln = 0, cur_len = LINE, vs_px = 50;
    bit inv = 0, hold_hs = 0, short_next = 0;
    int vs_rises = 0, lock_at = -1;
    bit tb_vsp = 0, lock_prev = 0;

    // Reference model state
    int m_hcnt, m_vcnt, m_ll, m_fl, m_hsp, m_vsp, m_hmis, m_lerr, m_st;
    int m_rgb, m_hso, m_vso, m_hb = 1, m_vb = 1;
    int m_hpol, m_vpol, m_hrp, m_vrp, m_hhi, m_hper, m_vhi, m_vper;

    function automatic bit raw_hs();
        if (hold_hs) return 1'b0;
        return (px < HSW) ^ inv;
    endfunction

    function automatic bit raw_vs();
        bit v;
        if (vs_px == 0) v = (ln < 2);
        else v = (ln == 0 && px >= vs_px) || ln == 1 || (ln == 2 && px < vs_px);
        return v ^ inv;
    endfunction

    task automatic model_step();
        int hn, vn, he, ve, lmis, sat, fmis, pchg, lk, ha, va, nhp, nvp;
        if (reset) begin
            m_hcnt = 0; m_vcnt = 0; m_ll = 0; m_fl = 0; m_hsp = 0; m_vsp = 0;
            m_hmis = 0; m_lerr = 0; m_st = 0; m_rgb = 0; m_hso = 0; m_vso = 0;
            m_hb = 1; m_vb = 1;
            m_hpol = 0; m_vpol = 0; m_hrp = 0; m_vrp = 0; m_hhi = 0; m_hper = 0; m_vhi = 0; m_vper = 0;
        end else if (ce_pix) begin
            hn = hsync_in ^ m_hpol;
            vn = vsync_in ^ m_vpol;
            he = hn && !m_hsp;
            ve = vn && !m_vsp;
            lmis = he && (((m_hcnt + 1) % (HMAX + 1)) != m_ll);
            sat  = !he && (m_hcnt == HMAX);
            fmis = ve && (m_vcnt != m_fl);
            nhp = m_hpol;
            nvp = m_vpol;
`ifdef VIDEO_COND_SYNC_POL_EN
            if (hsync_in && !m_hrp) begin
                nhp = (m_hhi > m_hper / 2); m_hhi = 1; m_hper = 1;
            end else begin
                if (m_hper < HMAX) m_hper++;
                if (hsync_in && m_hhi < HMAX) m_hhi++;
            end
            if (vsync_in && !m_vrp) begin
                nvp = (m_vhi > m_vper / 2); m_vhi = (he && vsync_in); m_vper = he;
            end else if (he) begin
                if (m_vper < VMAX) m_vper++;
                if (vsync_in && m_vhi < VMAX) m_vhi++;
            end
            m_hrp = hsync_in;
            m_vrp = vsync_in;
`endif
            pchg = (nhp != m_hpol) || (nvp != m_vpol);
            lk = (m_st == 2);
            ha = lk && (m_hcnt >= h_start) && (m_hcnt < h_start + HA);
            va = (m_vcnt >= v_start) && (m_vcnt < v_start + VA);
            m_hb = !ha;
            m_vb = !(va && lk);
            m_rgb = (ha && va) ? int'({r_in, g_in, b_in}) : 0;
            m_hso = hn;
            m_vso = vn;
            if (pchg) m_st = 0;
            else case (m_st)
                0: if (ve) m_st = 1;
                1: if (ve && !fmis && !m_hmis && !lmis && !m_lerr && !sat) m_st = 2;
                default: if (lmis || fmis || sat) m_st = 0;
            endcase
            m_hmis = ve ? 0 : (m_hmis || lmis);
            m_lerr = ve ? 0 : (m_lerr || sat);
            if (he) m_ll = (m_hcnt + 1) % (HMAX + 1);
            m_hcnt = he ? 0 : ((m_hcnt == HMAX) ? HMAX : m_hcnt + 1);
            if (ve) begin
                m_fl = m_vcnt; m_vcnt = 0;
            end else if (he && m_vcnt < VMAX) m_vcnt++;
            m_hsp = hn;
            m_vsp = vn;
            m_hpol = nhp;
            m_vpol = nvp;
        end
    endtask

    task automatic cyc(input int ce_pct);
        int exp_ctl;
        ce_pix   = ($urandom_range(0, 99) < ce_pct);
        hsync_in = raw_hs();
        vsync_in = raw_vs();
        r_in = CD'($urandom);
        g_in = CD'($urandom);
        b_in = CD'($urandom);
        @(posedge clk_video);
        model_step();
        if (reset) begin
            vs_rises = 0; tb_vsp = 0;
        end else if (ce_pix) begin
            if (vsync_in && !tb_vsp) vs_rises++;
            tb_vsp = vsync_in;
        end
        if (ce_pix && !hold_hs) begin
            px++;
            if (px >= cur_len) begin
                px = 0;
                ln = (ln + 1) % NL;
                cur_len = short_next ? SHORT : LINE;
                short_next = 0;
            end
        end
        #1;
        exp_ctl = (m_hso << 4) | (m_vso << 3) | (m_hb << 2) | (m_vb << 1) | int'(m_st == 2);
        check("rgb", int'({r_out, g_out, b_out}), m_rgb);
        check("ctl", int'({hsync_out, vsync_out, hblank_out, vblank_out, locked}), exp_ctl);
        check("line_len", int'(line_len), m_ll);
        check("frame_lines", int'(frame_lines), m_fl);
        if (locked && !lock_prev) lock_at = vs_rises;
        lock_prev = locked;
    endtask

    task automatic wait_pos(input int l, input int p, input int pct);
        int n;
        n = 0;
        while (!(ln == l && px == p)) begin
            cyc(pct);
            n++;
            if (n > 20000) begin
                check("wait_timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic frames(input int nf, input int pct);
        repeat (nf) begin
            wait_pos(0, 1, pct);
            wait_pos(0, 0, pct);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_hblank"}, int'(hblank_out), 1);
        check({tag, "_vblank"}, int'(vblank_out), 1);
        check({tag, "_rgb"}, int'({r_out, g_out, b_out}), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_line_len"}, int'(line_len), 0);
        check({tag, "_frame_lines"}, int'(frame_lines), 0);
    endtask

    initial begin
        int cnt, base;
        reset = 1'b1; ce_pix = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        r_in = '0; g_in = '0; b_in = '0;
        h_start = HW'(20); v_start = VW'(4);
        repeat (3) cyc(100);
        reset_checks("reset");
        reset = 1'b0;

        // Stable timing: lock on the third frame edge, nominal measurements
        frames(5, 85);
        check("lock_at_vs", lock_at, 3);
        check("p2_locked", int'(locked), 1);
        check("p2_line_len", int'(line_len), LINE);
        check("p2_frame_lines", int'(frame_lines), NL);
        wait_pos(7, 0, 85);
        cnt = 0;
        base = 0;
        while (base < LINE) begin
            cyc(85);
            if (ce_pix) begin
                base++;
                if (!hblank_out) cnt++;
            end
        end
        check("hblank_width", cnt, HA);

        // Reset mid-frame, then relock from scratch
        wait_pos(5, 60, 85);
        reset = 1'b1;
        repeat (3) cyc(85);
        reset = 1'b0;
        reset_checks("midreset");
        lock_at = -1;
        frames(4, 85);
        check("relock_at_vs", lock_at, 3);

        // One short line while locked
        wait_pos(3, 0, 90);
        short_next = 1;
        wait_pos(5, 1, 90);
        check("short_unlock", int'(locked), 0);
        base = vs_rises;
        lock_at = -1;
        frames(3, 90);
        check("short_relock_vs", lock_at - base, 2);

        // Pixel enable held low mid-line
        wait_pos(8, 30, 90);
        repeat (50) cyc(0);
        check("ce_hold_locked", int'(locked), 1);

        // Missing hsync saturates the line counter
        wait_pos(9, 20, 90);
        hold_hs = 1;
        repeat (2100) cyc(100);
        hold_hs = 0;
        check("sat_unlock", int'(locked), 0);
        frames(4, 90);
        check("sat_relock", int'(locked), 1);

        // hsync and vsync rising on the same ce
        wait_pos(5, 0, 90);
        vs_px = 0;
        frames(5, 90);
        check("coinc_locked", int'(locked), 1);
        check("coinc_frame_lines", int'(frame_lines), NL - 1);

        // Window placement: boundary at line end, then random
        wait_pos(5, 0, 90);
        vs_px = 50;
        frames(4, 90);
        h_start = HW'(LINE - HA);
        v_start = VW'(NL - VA);
        frames(2, 80);
        repeat (2) begin
            h_start = HW'($urandom_range(0, 75));
            v_start = VW'($urandom_range(0, 10));
            frames(2, 80);
        end
        check("win_locked", int'(locked), 1);

        // Inverted syncs
        h_start = HW'(20);
        v_start = VW'(4);
        wait_pos(5, 50, 90);
        inv = 1;
        frames(7, 90);
        check("inv_locked", int'(locked), 1);
        check("inv_line_len", int'(line_len), LINE);
        check("inv_frame_lines", int'(frame_lines), NL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
